perf_cnt_ctrl: RTL and testbench

Performance-counter controller that shares a bank of NUM_CNT 32-bit event counters among NUM_EVT single-bit event sources. Software configures, through a simple register port on the peripheral bus, which event each counter tracks. It also starts, stops and clears the bank and can bound the measurement to a fixed cycle window. The block raises an interrupt on counter overflow or on window completion. It sits between the core's event strobes (retire, stall, bus wait, etc.) and the system bus.

---
 rtl/perf_cnt_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_perf_cnt_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_cnt_ctrl.sv
// perf_cnt_ctrl: bank of NUM_CNT 32-bit event counters shared among NUM_EVT
// single-bit event strobes. A small register port configures which event each
// counter tracks, runs/stops/clears the bank, and bounds the run to an
// optional cycle window. Raises a level interrupt on overflow / window done.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   evt              event strobes, one event per cycle per high bit
//   reg_wr, reg_rd   single-cycle register write / read strobes
//   reg_addr         byte address (bits [1:0] ignored)
//   reg_wdata        write data
//   reg_rdata        read data, registered, nonzero only while reg_ack=1
//   reg_ack          registered one-cycle acknowledge for any strobe
//   irq              registered level interrupt = |(STATUS & IRQ_EN)
module perf_cnt_ctrl #(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [5:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_ack,
  output logic               irq
);

  localparam int unsigned DW   = 32;
  localparam int unsigned SELW = 3;

  localparam logic [3:0] WORD_CTRL   = 4'd0;
  localparam logic [3:0] WORD_WINDOW = 4'd1;
  localparam logic [3:0] WORD_STATUS = 4'd2;
  localparam logic [3:0] WORD_IRQEN  = 4'd3;
  localparam logic [3:0] WORD_CFG0   = 4'd4;
  localparam logic [3:0] WORD_CNT0   = 4'd8;
  localparam logic [3:0] NUM_EVT_W   = 4'(NUM_EVT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0]      elapsed_q;
  logic [DW-1:0]      window_q;
  logic [NUM_CNT-1:0] ovf_q;
  logic               done_q;
  logic [NUM_CNT-1:0] ien_ovf_q;
  logic               ien_done_q;
  logic [SELW-1:0]    cfg_sel_q [NUM_CNT];
  logic [NUM_CNT-1:0] cfg_en_q;
  logic [DW-1:0]      cnt_q     [NUM_CNT];

  logic [3:0]         word_c;
  logic               start_c, stop_c, clear_c;
  logic               wr_window_c, wr_status_c, wr_irqen_c;
  logic [NUM_CNT-1:0] cfg_wr_c, cnt_wr_c, inc_c, wrap_c;
  logic               win_hit_c;
  logic               run_entry_c;
  logic [DW-1:0]      rd_data_c;
  logic [7:0]         evt_x;

  // Address bits [1:0] are don't-care for word-aligned registers.
  logic unused_addr;
  assign unused_addr = ^reg_addr[1:0];

  // Zero-extended event vector so any 3-bit select indexes in range.
  assign evt_x = 8'(evt);

  // Write decode; CTRL bits are one-shot commands.
  always_comb begin
    word_c      = reg_addr[5:2];
    start_c     = reg_wr && (word_c == WORD_CTRL) && reg_wdata[0];
    stop_c      = reg_wr && (word_c == WORD_CTRL) && reg_wdata[1];
    clear_c     = reg_wr && (word_c == WORD_CTRL) && reg_wdata[2];
    wr_window_c = reg_wr && (word_c == WORD_WINDOW);
    wr_status_c = reg_wr && (word_c == WORD_STATUS);
    wr_irqen_c  = reg_wr && (word_c == WORD_IRQEN);
  end

  // Per-counter write select, increment qualification and wrap detect.
  always_comb begin
    cfg_wr_c = '0;
    cnt_wr_c = '0;
    inc_c    = '0;
    wrap_c   = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cfg_wr_c[i] = reg_wr && (word_c == (WORD_CFG0 + 4'(i)));
      cnt_wr_c[i] = reg_wr && (word_c == (WORD_CNT0 + 4'(i)));
      inc_c[i]    = (state_q == ST_RUN) && cfg_en_q[i] &&
                    ({1'b0, cfg_sel_q[i]} < NUM_EVT_W) &&
                    evt_x[cfg_sel_q[i]];
      // A wrap only counts if the increment actually lands.
      wrap_c[i]   = inc_c[i] && !clear_c && !cnt_wr_c[i] &&
                    (cnt_q[i] == 32'hFFFF_FFFF);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; STOP dominates START and window completion.
  always_comb begin
    state_d   = state_q;
    win_hit_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop_c)       state_d = ST_IDLE;
        else if (start_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_c) begin
          state_d = ST_IDLE;
        end else if ((window_q != '0) && (elapsed_q == (window_q - 32'd1))) begin
          state_d   = ST_DONE;
          win_hit_c = 1'b1;
        end
      end
      ST_DONE: begin
        if (stop_c)       state_d = ST_IDLE;
        else if (start_c) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    run_entry_c = (state_q != ST_RUN) && (state_d == ST_RUN);
  end

  // Cycle counter for window bounding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      elapsed_q <= '0;
    else if (clear_c || run_entry_c) elapsed_q <= '0;
    else if (state_q == ST_RUN)     elapsed_q <= elapsed_q + 32'd1;
  end

  // Configuration registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      window_q   <= '0;
      ien_ovf_q  <= '0;
      ien_done_q <= 1'b0;
      cfg_en_q   <= '0;
      for (int i = 0; i < NUM_CNT; i++) cfg_sel_q[i] <= '0;
    end else begin
      if (wr_window_c) window_q <= reg_wdata;
      if (wr_irqen_c) begin
        ien_ovf_q  <= reg_wdata[NUM_CNT-1:0];
        ien_done_q <= reg_wdata[16];
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cfg_wr_c[i]) begin
          cfg_sel_q[i] <= reg_wdata[SELW-1:0];
          cfg_en_q[i]  <= reg_wdata[8];
        end
      end
    end
  end

  // Sticky status: set events beat a simultaneous W1C.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ovf_q  <= (ovf_q & ~(wr_status_c ? reg_wdata[NUM_CNT-1:0] : '0)) | wrap_c;
      done_q <= (done_q & ~(wr_status_c && reg_wdata[16])) | win_hit_c;
    end
  end

  // Counters: CLEAR, then bus preload, then increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clear_c)          cnt_q[i] <= '0;
        else if (cnt_wr_c[i]) cnt_q[i] <= reg_wdata;
        else if (inc_c[i])    cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  // Read mux over current register values.
  always_comb begin
    rd_data_c = '0;
    case (word_c)
      WORD_CTRL:   rd_data_c = 32'(state_q);
      WORD_WINDOW: rd_data_c = window_q;
      WORD_STATUS: rd_data_c = {15'd0, done_q, 16'(ovf_q)};
      WORD_IRQEN:  rd_data_c = {15'd0, ien_done_q, 16'(ien_ovf_q)};
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (word_c == (WORD_CFG0 + 4'(i)))
            rd_data_c = {23'd0, cfg_en_q[i], 5'd0, cfg_sel_q[i]};
          if (word_c == (WORD_CNT0 + 4'(i)))
            rd_data_c = cnt_q[i];
        end
      end
    endcase
  end

  // Registered bus response and interrupt; a combined rd+wr returns 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      reg_ack   <= reg_rd || reg_wr;
      reg_rdata <= (reg_rd && !reg_wr) ? rd_data_c : '0;
      irq       <= (|(ovf_q & ien_ovf_q)) || (done_q && ien_done_q);
    end
  end

endmodule

// File: tb/tb_perf_cnt_ctrl.sv
// Directed testbench for perf_cnt_ctrl. A second instance with NUM_EVT=4
// shares the bus to exercise out-of-range event selects.
module tb_perf_cnt_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  evt;
  logic        reg_wr, reg_rd;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata, reg_rdata4;
  logic        reg_ack, reg_ack4;
  logic        irq, irq4;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] rd, rd4;

  always #5 clk = ~clk;

  perf_cnt_ctrl #(.NUM_CNT(4), .NUM_EVT(8)) u_dut (
    .clk(clk), .rstn(rstn), .evt(evt), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .irq(irq)
  );

  perf_cnt_ctrl #(.NUM_CNT(4), .NUM_EVT(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .evt(evt[3:0]), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata4),
    .reg_ack(reg_ack4), .irq(irq4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns on a falling edge.
  task automatic reg_write(input logic [5:0] addr, input logic [31:0] data);
    reg_wr = 1'b1; reg_addr = addr; reg_wdata = data;
    @(negedge clk);
    reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [31:0] data4);
    reg_rd = 1'b1; reg_addr = addr;
    @(negedge clk);
    reg_rd = 1'b0;
    check("ack", {31'd0, reg_ack}, 32'd1);
    data  = reg_rdata;
    data4 = reg_rdata4;
  endtask

  initial begin
    rstn = 1'b0; evt = '0; reg_wr = 1'b0; reg_rd = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",   {31'd0, reg_ack}, 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    reg_read(6'h00, rd, rd4); check("rst_state", rd, 32'd0);
    reg_read(6'h20, rd, rd4); check("rst_cnt0", rd, 32'd0);

    // Basic count: evt[2] for 10 cycles.
    reg_write(6'h10, 32'h102);
    reg_write(6'h00, 32'h1);
    evt = 8'h04;
    repeat (10) @(negedge clk);
    evt = '0;
    reg_write(6'h00, 32'h2);
    reg_read(6'h20, rd, rd4); check("basic_cnt0", rd, 32'd10);
    for (int i = 1; i < 4; i++) begin
      reg_read(6'(32 + 4 * i), rd, rd4); check("basic_cntx", rd, 32'd0);
    end
    reg_read(6'h00, rd, rd4); check("basic_state", rd, 32'd0);

    // Window of 5 cycles on counter 1.
    reg_write(6'h00, 32'h4);
    reg_write(6'h10, 32'h0);
    reg_write(6'h04, 32'd5);
    reg_write(6'h14, 32'h100);
    reg_write(6'h0C, 32'h10000);
    evt = 8'h01;
    reg_write(6'h00, 32'h1);
    repeat (10) @(negedge clk);
    evt = '0;
    reg_read(6'h24, rd, rd4); check("win_cnt1", rd, 32'd5);
    reg_read(6'h00, rd, rd4); check("win_state", rd, 32'd2);
    reg_read(6'h08, rd, rd4); check("win_status", rd, 32'h10000);
    check("win_irq", {31'd0, irq}, 32'd1);
    reg_write(6'h08, 32'h10000);
    @(negedge clk);
    check("win_irq_clr", {31'd0, irq}, 32'd0);
    reg_write(6'h04, 32'd0);
    reg_write(6'h00, 32'h2);

    // Overflow on counter 3 tracking evt[7].
    reg_write(6'h00, 32'h4);
    reg_write(6'h14, 32'h0);
    reg_write(6'h1C, 32'h107);
    reg_write(6'h2C, 32'hFFFF_FFFE);
    reg_write(6'h0C, 32'h8);
    reg_write(6'h00, 32'h1);
    evt = 8'h80;
    repeat (3) @(negedge clk);
    evt = '0;
    reg_write(6'h00, 32'h2);
    reg_read(6'h2C, rd, rd4); check("ovf_cnt3", rd, 32'd1);
    reg_read(6'h08, rd, rd4); check("ovf_status", rd, 32'h8);
    check("ovf_irq", {31'd0, irq}, 32'd1);
    reg_write(6'h0C, 32'h0);
    @(negedge clk);
    check("ovf_irq_mask", {31'd0, irq}, 32'd0);
    reg_write(6'h08, 32'h8);

    // Collisions on counter 0.
    reg_write(6'h00, 32'h4);
    reg_write(6'h1C, 32'h0);
    reg_write(6'h10, 32'h100);
    reg_write(6'h00, 32'h1);
    evt = 8'h01;
    repeat (3) @(negedge clk);
    reg_write(6'h20, 32'h100);
    evt = '0;
    reg_read(6'h20, rd, rd4); check("col_wr_cnt0", rd, 32'h100);
    reg_write(6'h20, 32'hFFFF_FFFF);
    evt = 8'h01;
    @(negedge clk);
    evt = '0;
    reg_read(6'h08, rd, rd4); check("col_ovf_set", rd, 32'h1);
    reg_write(6'h20, 32'hFFFF_FFFF);
    evt = 8'h01;
    reg_write(6'h08, 32'h1);
    evt = '0;
    reg_read(6'h08, rd, rd4); check("col_w1c_lose", rd, 32'h1);
    reg_read(6'h20, rd, rd4); check("col_wrap_cnt0", rd, 32'd0);
    evt = 8'h01;
    repeat (3) @(negedge clk);
    evt = '0;
    reg_read(6'h20, rd, rd4); check("clr_pre", rd, 32'd3);
    reg_write(6'h00, 32'h4);
    reg_read(6'h20, rd, rd4); check("clr_cnt0", rd, 32'd0);
    reg_read(6'h00, rd, rd4); check("clr_state", rd, 32'd1);
    reg_write(6'h00, 32'h2);

    // Bus corners.
    reg_read(6'h3C, rd, rd4); check("unmapped", rd, 32'd0);
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 6'h04; reg_wdata = 32'h55;
    @(negedge clk);
    reg_rd = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
    check("rdwr_ack", {31'd0, reg_ack}, 32'd1);
    check("rdwr_rdata", reg_rdata, 32'd0);
    @(negedge clk);
    check("rdwr_one_ack", {31'd0, reg_ack}, 32'd0);
    reg_read(6'h04, rd, rd4); check("rdwr_window", rd, 32'h55);
    reg_write(6'h04, 32'd0);
    reg_write(6'h00, 32'h3);
    reg_read(6'h00, rd, rd4); check("startstop", rd, 32'd0);

    // SEL=7: counts on 8-event block, never on 4-event block.
    reg_write(6'h00, 32'h4);
    reg_write(6'h10, 32'h107);
    reg_write(6'h00, 32'h1);
    evt = 8'hFF;
    repeat (4) @(negedge clk);
    evt = '0;
    reg_write(6'h00, 32'h2);
    reg_read(6'h20, rd, rd4);
    check("sel7_evt8", rd, 32'd4);
    check("sel7_evt4", rd4, 32'd0);

    // Reset mid-RUN with a pending ack and irq high.
    reg_write(6'h0C, 32'h1);
    @(negedge clk);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    reg_write(6'h10, 32'h100);
    reg_write(6'h00, 32'h1);
    evt = 8'h01;
    repeat (3) @(negedge clk);
    reg_rd = 1'b1; reg_addr = 6'h20;
    @(posedge clk);
    #1;
    rstn = 1'b0; reg_rd = 1'b0;
    #1;
    check("mid_rst_ack",   {31'd0, reg_ack}, 32'd0);
    check("mid_rst_rdata", reg_rdata, 32'd0);
    check("mid_rst_irq",   {31'd0, irq}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    evt = '0;
    reg_read(6'h20, rd, rd4); check("post_rst_cnt0", rd, 32'd0);
    reg_read(6'h00, rd, rd4); check("post_rst_state", rd, 32'd0);
    reg_read(6'h08, rd, rd4); check("post_rst_status", rd, 32'd0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
